// File: rtl/rs_opr_station_pkg.sv
// Shared widths and operand type for the reservation station.
package rs_opr_station_pkg;
  // Core-wide datapath constants
  localparam int DATA_LEN = 32;
  localparam int RRF_SEL  = 6;
  // Number of execution result broadcast buses snooped for wakeup
  localparam int NUM_BUS  = 4;

  // Source operand: data when rdy=1, RRF tag in the low RRF_SEL bits otherwise
  typedef struct packed {
    logic                rdy;
    logic [DATA_LEN-1:0] data;
  } opr_t;
endpackage

// File: rtl/rs_opr_station_opr_wakeup.sv
// Wakeup match for one pending operand against all result buses.
module rs_opr_station_opr_wakeup
  import rs_opr_station_pkg::*;
(
  input  logic                             i_pend,
  input  logic [RRF_SEL-1:0]               i_tag,
  input  logic [NUM_BUS-1:0][DATA_LEN-1:0] i_rslt,
  input  logic [NUM_BUS-1:0][RRF_SEL-1:0]  i_dst,
  input  logic [NUM_BUS-1:0]               i_kill,
  output logic [DATA_LEN-1:0]              o_data,
  output logic                             o_hit
);
  // Scan from the last bus down so the lowest-numbered matching bus wins
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    for (int b = NUM_BUS-1; b >= 0; b--) begin
      if (i_pend && !i_kill[b] && (i_dst[b] == i_tag)) begin
        o_hit  = 1'b1;
        o_data = i_rslt[b];
      end
    end
  end
endmodule

// File: rtl/rs_opr_station.sv
// 4-entry in-order-compacting reservation station for one execution pipe.
module rs_opr_station
  import rs_opr_station_pkg::*;
#(
  parameter int ENTRY_NUM = 4,
  parameter int ENTRY_SEL = 2,
  parameter int PAYLOAD_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prmiss,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [DATA_LEN-1:0]  alloc_opr1,
  input  logic                 alloc_rdy1,
  input  logic [DATA_LEN-1:0]  alloc_opr2,
  input  logic                 alloc_rdy2,
  input  logic [RRF_SEL-1:0]   alloc_rrftag,
  input  logic [PAYLOAD_W-1:0] alloc_payload,
  input  logic [DATA_LEN-1:0]  exrslt1,
  input  logic [DATA_LEN-1:0]  exrslt2,
  input  logic [DATA_LEN-1:0]  exrslt3,
  input  logic [DATA_LEN-1:0]  exrslt4,
  input  logic [RRF_SEL-1:0]   exdst1,
  input  logic [RRF_SEL-1:0]   exdst2,
  input  logic [RRF_SEL-1:0]   exdst3,
  input  logic [RRF_SEL-1:0]   exdst4,
  input  logic                 kill_spec1,
  input  logic                 kill_spec2,
  input  logic                 kill_spec3,
  input  logic                 kill_spec4,
  output logic                 issue_valid,
  input  logic                 issue_ack,
  output logic [DATA_LEN-1:0]  issue_src1,
  output logic [DATA_LEN-1:0]  issue_src2,
  output logic [RRF_SEL-1:0]   issue_rrftag,
  output logic [PAYLOAD_W-1:0] issue_payload,
  output logic [ENTRY_SEL:0]   busy_cnt
);
  localparam int CW = ENTRY_SEL + 1;

  logic [ENTRY_NUM-1:0]                r_valid;
  opr_t [ENTRY_NUM-1:0]                r_opr1, r_opr2;
  logic [ENTRY_NUM-1:0][RRF_SEL-1:0]   r_tag;
  logic [ENTRY_NUM-1:0][PAYLOAD_W-1:0] r_pay;
  logic [CW-1:0]                       r_cnt;

  logic [NUM_BUS-1:0][DATA_LEN-1:0] w_rslt;
  logic [NUM_BUS-1:0][RRF_SEL-1:0]  w_dst;
  logic [NUM_BUS-1:0]               w_kill;

  assign w_rslt = {exrslt4, exrslt3, exrslt2, exrslt1};
  assign w_dst  = {exdst4, exdst3, exdst2, exdst1};
  assign w_kill = {kill_spec4, kill_spec3, kill_spec2, kill_spec1};

  // Per-entry wakeup: stored operands after this cycle's broadcasts
  logic [ENTRY_NUM-1:0][DATA_LEN-1:0] w_wd1, w_wd2;
  logic [ENTRY_NUM-1:0]               w_hit1, w_hit2;
  opr_t [ENTRY_NUM-1:0]               w_wk1, w_wk2;

  for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
    rs_opr_station_opr_wakeup u_wk1 (
      .i_pend(r_valid[i] & ~r_opr1[i].rdy), .i_tag(r_opr1[i].data[RRF_SEL-1:0]),
      .i_rslt(w_rslt), .i_dst(w_dst), .i_kill(w_kill),
      .o_data(w_wd1[i]), .o_hit(w_hit1[i]));
    rs_opr_station_opr_wakeup u_wk2 (
      .i_pend(r_valid[i] & ~r_opr2[i].rdy), .i_tag(r_opr2[i].data[RRF_SEL-1:0]),
      .i_rslt(w_rslt), .i_dst(w_dst), .i_kill(w_kill),
      .o_data(w_wd2[i]), .o_hit(w_hit2[i]));
    assign w_wk1[i] = w_hit1[i] ? {1'b1, w_wd1[i]} : r_opr1[i];
    assign w_wk2[i] = w_hit2[i] ? {1'b1, w_wd2[i]} : r_opr2[i];
  end

  // Allocation-path wakeup so a broadcast in the dispatch cycle is not lost
  logic [DATA_LEN-1:0] w_awd1, w_awd2;
  logic                w_ahit1, w_ahit2;
  opr_t                w_aopr1, w_aopr2;

  rs_opr_station_opr_wakeup u_awk1 (
    .i_pend(~alloc_rdy1), .i_tag(alloc_opr1[RRF_SEL-1:0]),
    .i_rslt(w_rslt), .i_dst(w_dst), .i_kill(w_kill),
    .o_data(w_awd1), .o_hit(w_ahit1));
  rs_opr_station_opr_wakeup u_awk2 (
    .i_pend(~alloc_rdy2), .i_tag(alloc_opr2[RRF_SEL-1:0]),
    .i_rslt(w_rslt), .i_dst(w_dst), .i_kill(w_kill),
    .o_data(w_awd2), .o_hit(w_ahit2));

  assign w_aopr1 = w_ahit1 ? {1'b1, w_awd1} : {alloc_rdy1, alloc_opr1};
  assign w_aopr2 = w_ahit2 ? {1'b1, w_awd2} : {alloc_rdy2, alloc_opr2};

  // Oldest (lowest-index) entry with both operands ready
  logic                 w_found;
  logic [ENTRY_SEL-1:0] w_sel;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = ENTRY_NUM-1; i >= 0; i--) begin
      if (r_valid[i] && r_opr1[i].rdy && r_opr2[i].rdy) begin
        w_found = 1'b1;
        w_sel   = ENTRY_SEL'(i);
      end
    end
  end

  logic          w_issue, w_alloc;
  logic [CW-1:0] w_aslot;

  assign alloc_ready   = (r_cnt < CW'(ENTRY_NUM));
  assign issue_valid   = w_found & ~prmiss;
  assign w_issue       = issue_valid & issue_ack;
  assign w_alloc       = alloc_valid & alloc_ready & ~prmiss;
  // New entry lands just above the last survivor
  assign w_aslot       = r_cnt - CW'(w_issue);
  assign busy_cnt      = r_cnt;
  assign issue_src1    = w_found ? r_opr1[w_sel].data : '0;
  assign issue_src2    = w_found ? r_opr2[w_sel].data : '0;
  assign issue_rrftag  = w_found ? r_tag[w_sel]       : '0;
  assign issue_payload = w_found ? r_pay[w_sel]       : '0;

  // Shift sources padded with an empty slot so the top entry shifts in zeros
  logic [ENTRY_NUM:0]                w_svalid;
  opr_t [ENTRY_NUM:0]                w_s1, w_s2;
  logic [ENTRY_NUM:0][RRF_SEL-1:0]   w_stag;
  logic [ENTRY_NUM:0][PAYLOAD_W-1:0] w_spay;

  always_comb begin
    w_svalid = '0;
    w_s1     = '0;
    w_s2     = '0;
    w_stag   = '0;
    w_spay   = '0;
    w_svalid[ENTRY_NUM-1:0] = r_valid;
    w_s1[ENTRY_NUM-1:0]     = w_wk1;
    w_s2[ENTRY_NUM-1:0]     = w_wk2;
    w_stag[ENTRY_NUM-1:0]   = r_tag;
    w_spay[ENTRY_NUM-1:0]   = r_pay;
  end

  // Next state: close the gap left by the issued entry, then append
  logic [ENTRY_NUM-1:0]                w_nvalid;
  opr_t [ENTRY_NUM-1:0]                w_n1, w_n2;
  logic [ENTRY_NUM-1:0][RRF_SEL-1:0]   w_ntag;
  logic [ENTRY_NUM-1:0][PAYLOAD_W-1:0] w_npay;

  always_comb begin
    logic [CW-1:0] src;
    src      = '0;
    w_nvalid = '0;
    w_n1     = '0;
    w_n2     = '0;
    w_ntag   = '0;
    w_npay   = '0;
    for (int d = 0; d < ENTRY_NUM; d++) begin
      src         = (w_issue && d >= int'(w_sel)) ? CW'(d + 1) : CW'(d);
      w_nvalid[d] = w_svalid[src];
      w_n1[d]     = w_s1[src];
      w_n2[d]     = w_s2[src];
      w_ntag[d]   = w_stag[src];
      w_npay[d]   = w_spay[src];
      if (w_alloc && w_aslot == CW'(d)) begin
        w_nvalid[d] = 1'b1;
        w_n1[d]     = w_aopr1;
        w_n2[d]     = w_aopr2;
        w_ntag[d]   = alloc_rrftag;
        w_npay[d]   = alloc_payload;
      end
    end
  end

  // Entry storage; a mispredict discards everything including same-cycle alloc/issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_opr1  <= '0;
      r_opr2  <= '0;
      r_tag   <= '0;
      r_pay   <= '0;
      r_cnt   <= '0;
    end else if (prmiss) begin
      r_valid <= '0;
      r_opr1  <= '0;
      r_opr2  <= '0;
      r_tag   <= '0;
      r_pay   <= '0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_nvalid;
      r_opr1  <= w_n1;
      r_opr2  <= w_n2;
      r_tag   <= w_ntag;
      r_pay   <= w_npay;
      r_cnt   <= r_cnt + CW'(w_alloc) - CW'(w_issue);
    end
  end
endmodule

// File: tb/tb_rs_opr_station.sv
// Bench for rs_opr_station: hand-computed vector table, then random traffic vs a queue model.
module tb_rs_opr_station;
  import rs_opr_station_pkg::*;

  logic        clk = 1'b0, reset = 1'b0;
  logic        prmiss = 0, alloc_valid = 0, alloc_rdy1 = 0, alloc_rdy2 = 0, issue_ack = 0;
  logic [31:0] alloc_opr1 = 0, alloc_opr2 = 0;
  logic [5:0]  alloc_rrftag = 0;
  logic [15:0] alloc_payload = 0;
  logic [31:0] tb_rslt[4];
  logic [5:0]  tb_dst[4];
  logic        tb_kill[4];
  logic        alloc_ready, issue_valid;
  logic [31:0] issue_src1, issue_src2;
  logic [5:0]  issue_rrftag;
  logic [15:0] issue_payload;
  logic [2:0]  busy_cnt;

  int nvec = 0, nmis = 0;

  rs_opr_station dut (
    .clk(clk), .reset(reset), .prmiss(prmiss),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_opr1(alloc_opr1), .alloc_rdy1(alloc_rdy1),
    .alloc_opr2(alloc_opr2), .alloc_rdy2(alloc_rdy2),
    .alloc_rrftag(alloc_rrftag), .alloc_payload(alloc_payload),
    .exrslt1(tb_rslt[0]), .exrslt2(tb_rslt[1]), .exrslt3(tb_rslt[2]), .exrslt4(tb_rslt[3]),
    .exdst1(tb_dst[0]), .exdst2(tb_dst[1]), .exdst3(tb_dst[2]), .exdst4(tb_dst[3]),
    .kill_spec1(tb_kill[0]), .kill_spec2(tb_kill[1]), .kill_spec3(tb_kill[2]), .kill_spec4(tb_kill[3]),
    .issue_valid(issue_valid), .issue_ack(issue_ack),
    .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_rrftag(issue_rrftag), .issue_payload(issue_payload),
    .busy_cnt(busy_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: ordered queue of entries ----------------
  typedef struct {
    logic [31:0] o1, o2;
    bit          r1, r2;
    logic [5:0]  tg;
    logic [15:0] py;
  } ment_t;
  ment_t mq[$];

  // First live bus (1 before 2 before 3 before 4) carrying this tag
  function automatic bit bus_hit(input logic [31:0] opr, output logic [31:0] d);
    d = '0;
    for (int b = 0; b < 4; b++)
      if (!tb_kill[b] && tb_dst[b] == opr[5:0]) begin
        d = tb_rslt[b];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  function automatic int msel();
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic check_model();
    int s;
    s = msel();
    chk("m_busy", 32'(busy_cnt), 32'(mq.size()));
    chk("m_ardy", 32'(alloc_ready), 32'(mq.size() < 4));
    chk("m_ivld", 32'(issue_valid), 32'(s >= 0 && !prmiss));
    if (!prmiss) begin
      chk("m_src1", issue_src1, (s >= 0) ? mq[s].o1 : 32'd0);
      chk("m_src2", issue_src2, (s >= 0) ? mq[s].o2 : 32'd0);
      chk("m_tag", 32'(issue_rrftag), (s >= 0) ? 32'(mq[s].tg) : 32'd0);
      chk("m_pay", 32'(issue_payload), (s >= 0) ? 32'(mq[s].py) : 32'd0);
    end
  endtask

  task automatic update_model();
    int s;
    bit acc;
    ment_t n;
    logic [31:0] d;
    s = msel();
    if (prmiss) begin
      mq.delete();
      return;
    end
    acc = alloc_valid && mq.size() < 4;
    foreach (mq[i]) begin
      if (!mq[i].r1 && bus_hit(mq[i].o1, d)) begin mq[i].o1 = d; mq[i].r1 = 1; end
      if (!mq[i].r2 && bus_hit(mq[i].o2, d)) begin mq[i].o2 = d; mq[i].r2 = 1; end
    end
    if (s >= 0 && issue_ack) mq.delete(s);
    if (acc) begin
      n.o1 = alloc_opr1; n.r1 = alloc_rdy1; n.o2 = alloc_opr2; n.r2 = alloc_rdy2;
      n.tg = alloc_rrftag; n.py = alloc_payload;
      if (!n.r1 && bus_hit(n.o1, d)) begin n.o1 = d; n.r1 = 1; end
      if (!n.r2 && bus_hit(n.o2, d)) begin n.o2 = d; n.r2 = 1; end
      mq.push_back(n);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit av; logic [31:0] o1; bit r1; logic [31:0] o2; bit r2; logic [5:0] tg; logic [15:0] py;
    int bi; logic [5:0] bd; logic [31:0] bx; bit bk; bit ack; bit pm;
    bit eiv; logic [31:0] es1, es2; logic [5:0] etg; int ecnt; bit ear;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t V(bit av, logic [31:0] o1, bit r1, logic [31:0] o2, bit r2,
      logic [5:0] tg, logic [15:0] py, int bi, logic [5:0] bd, logic [31:0] bx, bit bk,
      bit ack, bit pm, bit eiv, logic [31:0] es1, logic [31:0] es2, logic [5:0] etg,
      int ecnt, bit ear);
    vec_t v;
    v.av = av; v.o1 = o1; v.r1 = r1; v.o2 = o2; v.r2 = r2; v.tg = tg; v.py = py;
    v.bi = bi; v.bd = bd; v.bx = bx; v.bk = bk; v.ack = ack; v.pm = pm;
    v.eiv = eiv; v.es1 = es1; v.es2 = es2; v.etg = etg; v.ecnt = ecnt; v.ear = ear;
    return v;
  endfunction

  task automatic clear_bus();
    for (int b = 0; b < 4; b++) begin
      tb_rslt[b] = 32'hDEAD_0000 + 32'(b); tb_dst[b] = 6'h3F; tb_kill[b] = 1'b1;
    end
  endtask

  function automatic logic [31:0] ropr(bit rdy);
    if (rdy) return $urandom();
    return ($urandom() & ~32'h3F) | 32'($urandom_range(0, 7));
  endfunction

  initial begin
    clear_bus();
    // reset / single ready op
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(V(1, 5, 1, 5, 1, 9, 16'h1234,    0, 0, 0, 0,         1, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         1, 0,  1, 5, 5, 9, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         0, 0,  0, 0, 0, 0, 0, 1));
    // tag 12 wakeup, killed broadcast first
    tbl.push_back(V(1, 12, 0, 3, 1, 1, 2,          0, 0, 0, 0,         1, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         1, 0,  0, 0, 0, 0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           2, 12, 32'hCAFE, 1, 1, 0,  0, 0, 0, 0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         1, 0,  0, 0, 0, 0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           2, 12, 32'hCAFE, 0, 1, 0,  0, 0, 0, 0, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         1, 0,  1, 32'hCAFE, 3, 1, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         0, 0,  0, 0, 0, 0, 0, 1));
    // wakeup in the allocation cycle
    tbl.push_back(V(1, 7, 0, 7, 0, 2, 3,           1, 7, 32'h11, 0,    1, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         1, 0,  1, 32'h11, 32'h11, 2, 1, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         0, 0,  0, 0, 0, 0, 0, 1));
    // fill to 4 with only entry1 ready
    tbl.push_back(V(1, 20, 0, 1, 1, 10, 4,         0, 0, 0, 0,         0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(V(1, 32'hA, 1, 32'hB, 1, 11, 5,  0, 0, 0, 0,         0, 0,  0, 0, 0, 0, 1, 1));
    tbl.push_back(V(1, 21, 0, 2, 1, 12, 6,         0, 0, 0, 0,         0, 0,  1, 32'hA, 32'hB, 11, 2, 1));
    tbl.push_back(V(1, 22, 0, 3, 1, 13, 7,         0, 0, 0, 0,         0, 0,  1, 32'hA, 32'hB, 11, 3, 1));
    // full: alloc rejected, entry1 issues
    tbl.push_back(V(1, 32'h55, 1, 32'h55, 1, 14, 8, 0, 0, 0, 0,        1, 0,  1, 32'hA, 32'hB, 11, 4, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           3, 21, 32'h77, 0,   0, 0,  0, 0, 0, 0, 3, 1));
    // alloc + issue at 3, wakeup lands on the shifted slot
    tbl.push_back(V(1, 32'h66, 1, 32'h67, 1, 15, 9, 1, 22, 32'h99, 0,  1, 0,  1, 32'h77, 2, 12, 3, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         1, 0,  1, 32'h99, 3, 13, 3, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           4, 20, 32'h88, 0,   1, 0,  1, 32'h66, 32'h67, 15, 2, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         0, 0,  1, 32'h88, 1, 10, 1, 1));
    // flush with alloc and ack in the same cycle
    tbl.push_back(V(1, 30, 0, 0, 1, 20, 10,        0, 0, 0, 0,         0, 0,  1, 32'h88, 1, 10, 1, 1));
    tbl.push_back(V(1, 31, 0, 0, 1, 21, 11,        0, 0, 0, 0,         0, 0,  1, 32'h88, 1, 10, 2, 1));
    tbl.push_back(V(1, 5, 1, 5, 1, 22, 12,         0, 0, 0, 0,         1, 1,  0, 0, 0, 0, 3, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         1, 0,  0, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    foreach (tbl[k]) begin
      clear_bus();
      alloc_valid = tbl[k].av; alloc_opr1 = tbl[k].o1; alloc_rdy1 = tbl[k].r1;
      alloc_opr2 = tbl[k].o2; alloc_rdy2 = tbl[k].r2; alloc_rrftag = tbl[k].tg;
      alloc_payload = tbl[k].py; issue_ack = tbl[k].ack; prmiss = tbl[k].pm;
      if (tbl[k].bi > 0) begin
        tb_dst[tbl[k].bi-1] = tbl[k].bd; tb_rslt[tbl[k].bi-1] = tbl[k].bx;
        tb_kill[tbl[k].bi-1] = tbl[k].bk;
      end
      @(negedge clk);
      chk($sformatf("v%0d_ivld", k), 32'(issue_valid), 32'(tbl[k].eiv));
      chk($sformatf("v%0d_busy", k), 32'(busy_cnt), 32'(tbl[k].ecnt));
      chk($sformatf("v%0d_ardy", k), 32'(alloc_ready), 32'(tbl[k].ear));
      if (!tbl[k].pm) begin
        chk($sformatf("v%0d_src1", k), issue_src1, tbl[k].es1);
        chk($sformatf("v%0d_src2", k), issue_src2, tbl[k].es2);
        chk($sformatf("v%0d_tag", k), 32'(issue_rrftag), 32'(tbl[k].etg));
      end
      check_model();
      @(posedge clk);
      update_model();
      #1;
    end

    // ---------------- random traffic against the model ----------------
    for (int c = 0; c < 1500; c++) begin
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_rdy1 = $urandom_range(0, 1); alloc_opr1 = ropr(alloc_rdy1);
      alloc_rdy2 = $urandom_range(0, 1); alloc_opr2 = ropr(alloc_rdy2);
      alloc_rrftag = 6'($urandom()); alloc_payload = 16'($urandom());
      for (int b = 0; b < 4; b++) begin
        tb_dst[b] = 6'($urandom_range(0, 7)); tb_rslt[b] = $urandom();
        tb_kill[b] = ($urandom_range(0, 1) == 0);
      end
      issue_ack = ($urandom_range(0, 9) < 6);
      prmiss = ($urandom_range(0, 39) == 0);
      if (c == 700) begin
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_cnt), 32'd0);
        chk("rst_ivld", 32'(issue_valid), 32'd0);
        chk("rst_ardy", 32'(alloc_ready), 32'd1);
        chk("rst_src1", issue_src1, 32'd0);
        mq.delete();
        #1 reset = 1'b1;
      end
      @(negedge clk);
      check_model();
      @(posedge clk);
      update_model();
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/rs_opr_station.md
Name: rs_opr_station

Overview:
- 4-entry in-order-compacting reservation station for one execution pipe.
- Sits between dispatch and the execution unit. Captures up to two source operands per instruction; a not-ready operand holds an RRF tag instead of data.
- Snoops the execution result broadcast buses to wake up pending operands. Issues the oldest fully-ready entry to the execution unit, one per cycle.

Parameters:
- ENTRY_NUM, 4, number of station entries
- ENTRY_SEL, 2, log2(ENTRY_NUM)
- PAYLOAD_W, 16, opaque decoded-op payload carried to issue

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- prmiss  input  1  branch mispredict; flush all entries
- alloc_valid  input  1  dispatch presents an instruction
- alloc_ready  output  1  station can accept (count < ENTRY_NUM)
- alloc_opr1  input  `DATA_LEN  operand 1: data if alloc_rdy1, else RRF tag in low `RRF_SEL bits
- alloc_rdy1  input  1  operand 1 is data
- alloc_opr2  input  `DATA_LEN  operand 2, same encoding as alloc_opr1
- alloc_rdy2  input  1  operand 2 is data
- alloc_rrftag  input  `RRF_SEL  destination RRF tag
- alloc_payload  input  PAYLOAD_W  decoded op
- exrsltN  input  `DATA_LEN  result bus N data, N = 1..4
- exdstN  input  `RRF_SEL  result bus N destination tag, N = 1..4
- kill_specN  input  1  result bus N invalid/speculatively killed, N = 1..4
- issue_valid  output  1  an entry is fully ready
- issue_ack  input  1  execution unit accepts issue this cycle
- issue_src1  output  `DATA_LEN  operand 1 data of the issued entry
- issue_src2  output  `DATA_LEN  operand 2 data of the issued entry
- issue_rrftag  output  `RRF_SEL  destination tag of the issued entry
- issue_payload  output  PAYLOAD_W  payload of the issued entry
- busy_cnt  output  ENTRY_SEL+1  number of valid entries

Behaviour:
- Entry state: valid, opr1, rdy1, opr2, rdy2, rrftag, payload. Entries are kept compacted: entry 0 is oldest, valid entries are contiguous from 0.
- Reset (async, reset==0): all entries invalid, all fields zero, busy_cnt=0, issue_valid=0, alloc_ready=1, all issue data outputs 0.
- Wakeup, per valid entry, per operand with rdy=0:
  - A bus matches when ~kill_specN & (exdstN == opr[`RRF_SEL-1:0]).
  - On a match, opr takes exrsltN and rdy is set at the next edge.
  - Priority when several buses match: 1 > 2 > 3 > 4.
  - An operand already ready never changes.
- Allocation-cycle wakeup: incoming operands with alloc_rdy=0 are checked against the buses in the allocation cycle. A matching operand is stored already ready with the bus data, so no broadcast is missed.
- Issue select (combinational from registered state): lowest-index valid entry with rdy1 & rdy2. issue_valid=1 iff such an entry exists and prmiss=0. Data outputs show the selected entry; they are 0 when no entry is selected.
- Latency: an operand woken in cycle t makes its entry eligible at t+1. Allocate-to-issue minimum is 1 cycle (alloc at t, issue_valid at t+1).
- Removal: on issue_valid & issue_ack, the selected entry is removed at the edge. Entries above it shift down one slot. Wakeups that cycle are applied to the shifted destination slot.
- Allocation:
  - alloc_ready = (busy_cnt < ENTRY_NUM). It does not credit a same-cycle issue.
  - Accepted when alloc_valid & alloc_ready & ~prmiss.
  - Written to slot busy_cnt, or busy_cnt-1 when an issue is removed in the same cycle.
- Simultaneous alloc + issue: busy_cnt is unchanged. Alloc only: +1. Issue only: -1.
- Flush: prmiss=1 invalidates all entries at the edge. Same-cycle alloc and issue_ack are ignored. busy_cnt becomes 0.
- Reset mid-operation: all in-flight entries are discarded immediately; no issue occurs.
- Tags are compared on `RRF_SEL bits only. Upper operand bits are don't-care while rdy=0.

Decomposition:
- DATA_LEN and RRF_SEL come from constants.vh; no new shared constants.
- Natural sub-module: opr_wakeup. It is combinational: one operand plus 4 buses in, woken data and a hit flag out.
- It is instantiated 2x per entry plus 2x on the allocation path.

Test Plan:
- Reset release, no stimulus -> busy_cnt=0, alloc_ready=1, issue_valid=0, all issue outputs 0.
- Alloc opr1=5 (rdy), opr2=5 (rdy), rrftag=9; issue_ack=1 -> issue_valid next cycle, issue_src1=5, issue_src2=5, issue_rrftag=9, busy_cnt returns to 0.
- Alloc opr1 tag 12 (not rdy); two cycles later exdst2=12, exrslt2=0xCAFE, kill_spec2=0 -> issue_valid one cycle after broadcast, issue_src1=0xCAFE. The same broadcast with kill_spec2=1 -> entry stays unready.
- Alloc with tag 7 in the same cycle that exdst1=7, exrslt1=0x11 -> entry ready at allocation, issue next cycle with src=0x11.
- Fill 4 entries, where entry1 is ready and entries 0, 2, 3 are not -> alloc_ready=0, entry1 issues first. Then alloc plus issue in the same cycle at full keeps busy_cnt=3 and the ordering is preserved.
- 3 entries valid, assert prmiss together with alloc_valid and issue_ack -> busy_cnt=0 next cycle, nothing issued, no entry written.
